// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done operand and result bundle for serial_subtractor
interface serial_subtractor_if #(
    parameter int N = 8
) ();
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/full_subtractor_cell.sv
// rtl/full_subtractor_cell.sv - combinational 1-bit subtractor, d = a - b - bin
module full_subtractor_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - N-bit subtractor evaluated LSB first, one bit per clock
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    sub_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          br_q, br_d;
    logic          a_msb_q, a_msb_d;
    logic          b_msb_q, b_msb_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          borrow_out_q, borrow_out_d;
    logic          overflow_q, overflow_d;

    logic          cell_d;
    logic          cell_bout;
    logic [N-1:0]  diff_shift;

    full_subtractor_cell u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    // Result bits enter at the MSB so bit 0 lands in place after N shifts.
    generate
        if (N == 1) begin : g_shift_1
            assign diff_shift = cell_d;
        end else begin : g_shift_n
            assign diff_shift = {cell_d, diff_q[N-1:1]};
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        br_d         = br_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.borrow_in;
                    a_msb_d = bus.a[N-1];
                    b_msb_d = bus.b[N-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d          = a_q >> 1;
                b_d          = b_q >> 1;
                br_d         = cell_bout;
                diff_d       = diff_shift;
                borrow_out_d = cell_bout;
                // Only the value written on the final edge matters; that is when cell_d is the MSB.
                overflow_d   = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            br_q         <= 1'b0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            br_q         <= br_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed bench for serial_subtractor at N=1, 8, 16
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    serial_subtractor_if #(.N(1))  if1  ();
    serial_subtractor_if #(.N(8))  if8  ();
    serial_subtractor_if #(.N(16)) if16 ();

    serial_subtractor #(.N(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1.slave));
    serial_subtractor #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_subtractor #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction, unsigned for borrow, signed for overflow.
    task automatic ref_sub(input int w, input logic [15:0] a, input logic [15:0] b, input bit bi,
                           output logic [15:0] d, output bit bo, output bit ov);
        longint mod, ua, ub, sa, sb, full, sres;
        mod  = longint'(1) << w;
        ua   = longint'(a) % mod;
        ub   = longint'(b) % mod;
        full = ua - ub - longint'(bi);
        bo   = (full < 0);
        d    = 16'(((full % mod) + mod) % mod);
        sa   = (ua >= mod / 2) ? ua - mod : ua;
        sb   = (ub >= mod / 2) ? ub - mod : ub;
        sres = sa - sb - longint'(bi);
        ov   = (sres < -(mod / 2)) || (sres > (mod / 2) - 1);
    endtask

    task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic bi);
        case (w)
            1: begin if1.start = st; if1.a = a[0]; if1.b = b[0]; if1.borrow_in = bi; end
            8: begin if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.borrow_in = bi; end
            default: begin if16.start = st; if16.a = a; if16.b = b; if16.borrow_in = bi; end
        endcase
    endtask

    task automatic sample(input int w, output logic dn, output logic bsy, output logic [15:0] df,
                          output logic bo, output logic ov);
        case (w)
            1: begin dn = if1.done; bsy = if1.busy; df = {15'b0, if1.diff};
                     bo = if1.borrow_out; ov = if1.overflow; end
            8: begin dn = if8.done; bsy = if8.busy; df = {8'b0, if8.diff};
                     bo = if8.borrow_out; ov = if8.overflow; end
            default: begin dn = if16.done; bsy = if16.busy; df = if16.diff;
                     bo = if16.borrow_out; ov = if16.overflow; end
        endcase
    endtask

    // Waits for done (bounded), returning cycles counted from the start-assert negedge.
    task automatic wait_done(input int w, input int first, output int cycles);
        logic dn, bsy, bo, ov;
        logic [15:0] df;
        cycles = first;
        sample(w, dn, bsy, df, bo, ov);
        while (!dn && cycles < 200) begin
            @(negedge clk);
            cycles++;
            sample(w, dn, bsy, df, bo, ov);
        end
    endtask

    task automatic check_result(input string tag, input int w, input logic [15:0] a,
                                input logic [15:0] b, input bit bi);
        logic dn, bsy, bo, ov;
        logic [15:0] df, ed;
        bit ebo, eov;
        ref_sub(w, a, b, bi, ed, ebo, eov);
        sample(w, dn, bsy, df, bo, ov);
        check($sformatf("%s_done", tag), 32'(dn), 32'd1);
        check($sformatf("%s_diff", tag), 32'(df), 32'(ed));
        check($sformatf("%s_bout", tag), 32'(bo), 32'(ebo));
        check($sformatf("%s_ovf", tag), 32'(ov), 32'(eov));
    endtask

    task automatic run_op(input string tag, input int w, input logic [15:0] a, input logic [15:0] b,
                          input bit bi);
        int cycles;
        logic dn, bsy, bo, ov;
        logic [15:0] df, df_hold;
        @(negedge clk);
        drive(w, 1'b1, a, b, bi);
        @(negedge clk);
        drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        wait_done(w, 1, cycles);
        check($sformatf("%s_lat", tag), 32'(cycles), 32'(w + 1));
        check_result(tag, w, a, b, bi);
        sample(w, dn, bsy, df_hold, bo, ov);
        repeat (2) @(negedge clk);
        sample(w, dn, bsy, df, bo, ov);
        check($sformatf("%s_pulse", tag), 32'({dn, bsy}), 32'd0);
        check($sformatf("%s_hold", tag), 32'(df), 32'(df_hold));
    endtask

    initial begin
        int cycles;
        int n_done;
        logic dn, bsy, bo, ov;
        logic [15:0] df;
        logic [15:0] ra, rb;
        bit rbi;
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1;
        drive(1, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(16, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        sample(8, dn, bsy, df, bo, ov);
        check("rst8_outputs", {27'd0, dn, bsy, bo, ov, |df}, 32'd0);
        sample(16, dn, bsy, df, bo, ov);
        check("rst16_outputs", {27'd0, dn, bsy, bo, ov, |df}, 32'd0);
        rst = 1'b0;

        run_op("d8_5a_3c", 8, 16'h5A, 16'h3C, 1'b0);
        run_op("d8_00_01", 8, 16'h00, 16'h01, 1'b0);
        run_op("d8_80_01", 8, 16'h80, 16'h01, 1'b0);
        run_op("d8_10_0f_b", 8, 16'h10, 16'h0F, 1'b1);
        run_op("d8_00_ff_b", 8, 16'h00, 16'hFF, 1'b1);
        run_op("d8_80_00_b", 8, 16'h80, 16'h00, 1'b1);
        run_op("d8_7f_80", 8, 16'h7F, 16'h80, 1'b0);

        // start held high through RUN must neither disturb operands nor re-trigger.
        @(negedge clk);
        drive(8, 1'b1, 16'hC3, 16'h5E, 1'b1);
        @(negedge clk);
        cycles = 1;
        sample(8, dn, bsy, df, bo, ov);
        while (!dn && cycles < 200) begin
            drive(8, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            @(negedge clk);
            cycles++;
            sample(8, dn, bsy, df, bo, ov);
        end
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        check("hold_start_lat", 32'(cycles), 32'd9);
        check_result("hold_start", 8, 16'hC3, 16'h5E, 1'b1);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            sample(8, dn, bsy, df, bo, ov);
            if (dn) n_done++;
        end
        check("hold_start_extra_done", 32'(n_done), 32'd0);

        // Back-to-back: second start in the DONE cycle.
        @(negedge clk);
        drive(8, 1'b1, 16'h33, 16'h44, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        wait_done(8, 1, cycles);
        check("b2b_first_lat", 32'(cycles), 32'd9);
        check_result("b2b_first", 8, 16'h33, 16'h44, 1'b0);
        drive(8, 1'b1, 16'hA5, 16'h5A, 1'b1);
        @(negedge clk);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        sample(8, dn, bsy, df, bo, ov);
        check("b2b_no_gap_busy", 32'(bsy), 32'd1);
        wait_done(8, 1, cycles);
        check("b2b_second_lat", 32'(cycles), 32'd9);
        check_result("b2b_second", 8, 16'hA5, 16'h5A, 1'b1);

        // Asynchronous abort partway through RUN.
        @(negedge clk);
        drive(8, 1'b1, 16'h5A, 16'h3C, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 sample(8, dn, bsy, df, bo, ov);
        check("abort_outputs", {27'd0, dn, bsy, bo, ov, |df}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            sample(8, dn, bsy, df, bo, ov);
            if (dn || bsy) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        run_op("after_abort", 8, 16'h5A, 16'h3C, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("n1_%0d", i), 1, 16'(i[2]), 16'(i[1]), i[0]);
        end

        for (int i = 0; i < 30; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom);
            run_op($sformatf("r16_%0d", i), 16, ra, rb, rbi);
        end
        for (int i = 0; i < 10; i++) begin
            ra  = 16'($urandom_range(0, 255));
            rb  = 16'($urandom_range(0, 255));
            rbi = 1'($urandom);
            run_op($sformatf("r8_%0d", i), 8, ra, rb, rbi);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor, the sequential borrow-chain counterpart of the team's combinational ripple adder. It computes diff = a − b − borrow_in one bit per clock, LSB first, through a single 1-bit subtractor cell. A start/done handshake drives it, and it sits next to the adder in area-constrained datapaths where an N-bit parallel borrow chain is not affordable.

## Interface
- N, default 8, operand and result width; legal range is N ≥ 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when the block is in IDLE or DONE.
- a  in  N  minuend; captured on the accepting edge.
- b  in  N  subtrahend; captured on the accepting edge.
- borrow_in  in  1  initial borrow; captured on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- diff  out  N  result; holds until the next accepted start.
- borrow_out  out  1  final borrow (1 means a < b + borrow_in, unsigned).
- overflow  out  1  signed two's-complement overflow of a − b − borrow_in.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:**
  - start=1 latches a, b and borrow_in into shift/borrow registers.
  - It clears the bit counter and moves to RUN.
  - start=0 keeps the FSM in IDLE.
- **RUN:** each edge does the following:
  - The cell computes d = a0 ^ b0 ^ br and br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into diff from the MSB side. The a and b registers shift right.
  - The borrow register takes br' and the counter increments.
  - On the edge that processes bit N−1, the FSM goes to DONE.
- **DONE:**
  - done=1 for exactly this cycle.
  - The diff register now holds the complete result.
  - borrow_out equals the final borrow register.
  - overflow = (a_msb ^ b_msb) & (diff[N-1] ^ a_msb). a_msb and b_msb are the MSBs captured at start and held in dedicated flops.
  - start=1 in DONE is accepted like IDLE (back-to-back) and goes to RUN. Otherwise the FSM goes to IDLE.
- start while in RUN is ignored; the operands in flight are unaffected.
- diff, borrow_out and overflow are registers. They change only during RUN or reset, and they hold their values through IDLE.
- The partial diff is visible during RUN and is not meaningful until done.
- Arithmetic is modulo 2^N. borrow_in participates as a full borrow at bit 0.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow_out=0, overflow=0, state IDLE, counter 0.
- Reset asserted mid-RUN aborts immediately and asynchronously. No done pulse is produced for the aborted operation.
- Latency: with start accepted at edge k, RUN occupies edges k+1 … k+N and done is high in the cycle after edge k+N. That gives N+1 cycles from start acceptance to done.
- Throughput: back-to-back starts give one result every N+1 cycles.
- N=1: RUN lasts one edge, and done follows two cycles after acceptance.
- The counter is $clog2(N)-wide, minimum 1 bit. The terminal compare is against N−1, so there is no wrap into an extra RUN cycle.

## Structure
- Package serial_sub_pkg:
  - Holds the typedef of the state enum (IDLE, RUN, DONE), 2 bits.
  - Holds no width constants; N stays a module parameter.
- Sub-module full_subtractor_cell is purely combinational: inputs a, b, bin; outputs d, bout.
  - It is instantiated once in serial_subtractor.
  - It is reusable by a future parallel subtractor.

## Test plan
- N=8: a=0x5A, b=0x3C, borrow_in=0, start 1 cycle → done after 9 cycles; diff=0x1E, borrow_out=0, overflow=0.
- N=8: a=0x00, b=0x01 → diff=0xFF, borrow_out=1, overflow=0. Then a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1.
- N=8: a=0x10, b=0x0F, borrow_in=1 → diff=0x00, borrow_out=0. Then a=0x00, b=0xFF, borrow_in=1 → diff=0x00, borrow_out=1.
- Sequencing: start asserted on every RUN cycle → ignored; exactly one done. A second start in the DONE cycle → second result after a further 9 cycles, with no idle gap.
- Reset: rst pulsed at RUN bit 3 → all outputs 0 and state IDLE. No done appears, and a fresh start completes correctly.
- N=1 instance: all 8 combinations of a, b and borrow_in → diff and borrow_out match the truth table; done follows 2 cycles after start. Random regression at N=16 compares against a − b − borrow_in.
